prng_vn_extractor: RTL and testbench
====================================

PRNG_VN_EXTRACTOR -- requirements
Module: prng_vn_extractor

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, 2..16.
REQ-002 Parameter REP_LIMIT, default 4: identical consecutive accepted bytes that trip the repetition test, 2..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ena  input  1  design enable; low freezes the extractor and the repetition test.
REQ-006 in_data  input  8  raw PRNG byte from the upstream LFSR stage.
REQ-007 in_valid  input  1  in_data holds a fresh byte.
REQ-008 in_ready  output  1  extractor can accept a byte this cycle.
REQ-009 out_data  output  8  debiased byte at the FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 rep_fail  output  1  sticky repetition-test failure flag.

Function
REQ-014 FSM states SHALL be IDLE and PAIR; in_ready = ena & (state==IDLE), combinational.
REQ-015 Accept = in_valid & in_ready; on accept the byte SHALL be latched, pair index set to 0, and state set to PAIR.
REQ-016 In PAIR with ena high, each cycle SHALL process one pair, MSB first: index 0 = bits[7:6], 1 = [5:4], 2 = [3:2], 3 = [1:0].
REQ-017 Pair 10 SHALL emit bit 1, pair 01 SHALL emit bit 0, and pairs 00/11 SHALL emit nothing.
REQ-018 Emitted bits SHALL shift MSB-first into an 8-bit assembly register with a 3-bit count; the first emitted bit lands in out byte bit 7.
REQ-019 The eighth emitted bit SHALL push the completed byte into the FIFO on the same edge and clear the count; partial bytes persist across input bytes.
REQ-020 A step that would push while the FIFO is full and no pop occurs that cycle SHALL stall: no index advance, no bit consumed, state held.
REQ-021 After index 3 completes, state SHALL return to IDLE; the best-case throughput is 1 input byte per 5 cycles.
REQ-022 ena low SHALL hold FSM, index, assembly register and repetition counter; FIFO pops still proceed.
REQ-023 The FIFO SHALL be first-word fall-through: out_data = head, out_valid = (level != 0), pop = out_valid & out_ready.
REQ-024 A simultaneous push and pop SHALL be legal at any level, including full (level unchanged) and empty with push (no pop occurs; out_valid asserts the next cycle).
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL never exceed FIFO_DEPTH or underflow.
REQ-026 Repetition test: on each accept, if in_data equals the previously accepted byte, the run counter SHALL increment (saturating), else reset to 1; the first accept after reset starts run = 1.
REQ-027 rep_fail SHALL set on the edge where the run reaches REP_LIMIT and stay set until reset; the extractor keeps running.

Reset
REQ-028 While rst_n is low at a clock edge: state=IDLE, index=0, assembly register and count=0, FIFO empty (level 0, out_valid 0, out_data 8'h00), run counter 0, no previous byte, rep_fail=0.
REQ-029 Reset mid-PAIR or with a partial byte SHALL discard all in-flight bits and FIFO contents; in_ready is high on the first cycle after release if ena is high.

Structure
REQ-030 Shared package prng_pkg SHALL hold the FSM state enum, the FIFO_DEPTH/REP_LIMIT defaults and the pair-code constants.
REQ-031 The FIFO SHALL be a sub-module prng_byte_fifo (push, pop, data, level, full, empty) with the same clock and reset.
REQ-032 There SHALL be no combinational path from in_valid to out_valid/out_data.

Verification
REQ-033 Two accepted bytes 8'h66, 8'h66 (pairs 01,10,01,10) -> after the 2nd byte's 4th step, out_data=8'h55, out_valid=1, fifo_level=1.
REQ-034 Accept 8'h00 then 8'hFF, then 8'h99, 8'h99 -> 8'h00 and 8'hFF emit nothing; the single output is 8'hAA.
REQ-035 Accept 8'hA5 four times consecutively -> rep_fail rises on the 4th accept edge, stays 1 after 8'h3C is accepted; 8'hA5,8'h3C alternating -> never sets.
REQ-036 out_ready=0, FIFO_DEPTH=4, feed 8'h66 stream until level=4 -> next completing step stalls, in_ready stays 0; one pop cycle -> push proceeds the same edge, level stays 4.
REQ-037 Assert rst_n=0 for one edge mid-PAIR with level=2 and 5 partial bits -> level=0, out_valid=0, rep_fail=0, state IDLE; next 8'h66,8'h66 again yields exactly 8'h55.
REQ-038 Drop ena for 3 cycles mid-PAIR with out_ready=1 -> index frozen, pending FIFO entries drain, processing resumes at the same pair.

Source files
------------

// File: rtl/prng_vn_extractor_pkg.sv
// Shared definitions for the von Neumann PRNG extractor: FSM states,
// parameter defaults and the bit-pair codes that produce an output bit.
package prng_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PAIR = 1'b1
    } state_t;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int REP_LIMIT_DEFAULT  = 4;

    // Von Neumann pair codes: 10 yields a one, 01 yields a zero,
    // 00 and 11 are discarded.
    localparam logic [1:0] PAIR_EMIT_ONE  = 2'b10;
    localparam logic [1:0] PAIR_EMIT_ZERO = 2'b01;

    // Width of the repetition run counter; REP_LIMIT never exceeds 15.
    localparam int RUN_W = 4;

endpackage

// File: rtl/prng_vn_extractor_fifo.sv
// First-word fall-through byte FIFO holding completed debiased bytes.
// Push while full is accepted only when a pop happens on the same edge.
module prng_byte_fifo
    import prng_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [LW-1:0] level_q;
    logic          doPush;
    logic          doPop;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign level  = level_q;
    // The head reads as zero while empty so the output is defined after reset.
    assign rdata  = empty ? 8'h00 : mem_q[rdPtr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/prng_vn_extractor.sv
// Von Neumann debiasing extractor with a repetition health test.
// Each accepted byte is walked as four bit pairs, MSB pair first; surviving
// bits are packed MSB-first into bytes that are queued in an output FIFO.
module prng_vn_extractor
    import prng_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int REP_LIMIT  = REP_LIMIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        rep_fail
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       asm_q, asm_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [7:0]       prev_q, prev_d;
    logic             prevValid_q, prevValid_d;
    logic             repFail_q, repFail_d;

    logic       accept;
    logic [1:0] pair;
    logic       emit;
    logic       emitBit;
    logic       inPair;
    logic       fifoPop;
    logic       fifoPush;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       stall;
    logic       step;
    logic [7:0] withBit;

    assign in_ready  = ena & (state_q == IDLE);
    assign accept    = in_valid & in_ready;
    assign out_valid = ~fifoEmpty;
    assign fifoPop   = out_valid & out_ready;
    assign rep_fail  = repFail_q;

    // Select the current bit pair, most significant pair first.
    always_comb begin
        pair = byte_q[7:6];
        case (idx_q)
            2'd0:    pair = byte_q[7:6];
            2'd1:    pair = byte_q[5:4];
            2'd2:    pair = byte_q[3:2];
            default: pair = byte_q[1:0];
        endcase
    end

    assign emit    = (pair == PAIR_EMIT_ONE) | (pair == PAIR_EMIT_ZERO);
    assign emitBit = (pair == PAIR_EMIT_ONE);
    assign inPair  = (state_q == PAIR) & ena;
    // A step that would complete a byte waits while the FIFO is full and nothing leaves it.
    assign stall    = inPair & emit & (cnt_q == 3'd7) & fifoFull & ~fifoPop;
    assign step     = inPair & ~stall;
    assign fifoPush = step & emit & (cnt_q == 3'd7);
    // Bits land at position 7-count, which packs them MSB-first.
    assign withBit  = emitBit ? (asm_q | (8'h80 >> cnt_q)) : asm_q;

    // Extractor next state: latch on accept, then one pair per enabled cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        if (accept) begin
            byte_d  = in_data;
            idx_d   = 2'd0;
            state_d = PAIR;
        end else if (step) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                state_d = IDLE;
            end
            if (emit) begin
                cnt_d = cnt_q + 3'd1;
                asm_d = (cnt_q == 3'd7) ? 8'h00 : withBit;
            end
        end
    end

    // Repetition health test on accepted bytes; the failure flag is sticky.
    always_comb begin
        run_d       = run_q;
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
        repFail_d   = repFail_q;
        if (accept) begin
            if (prevValid_q && (in_data == prev_q)) begin
                run_d = (run_q == '1) ? run_q : run_q + 1'b1;
            end else begin
                run_d = RUN_W'(1);
            end
            prev_d      = in_data;
            prevValid_d = 1'b1;
            if (run_d == RUN_W'(REP_LIMIT)) begin
                repFail_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            byte_q      <= 8'h00;
            asm_q       <= 8'h00;
            cnt_q       <= 3'd0;
            run_q       <= '0;
            prev_q      <= 8'h00;
            prevValid_q <= 1'b0;
            repFail_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
            repFail_q   <= repFail_d;
        end
    end

    prng_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) uFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (withBit),
        .rdata (out_data),
        .level (fifo_level),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

endmodule

// File: tb/tb_prng_vn_extractor.sv
// Directed testbench for prng_vn_extractor with hand-computed expectations.
module tb_prng_vn_extractor;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_level;
    logic       rep_fail;

    int testsRun;
    int testsFailed;

    prng_vn_extractor #(
        .FIFO_DEPTH (4),
        .REP_LIMIT  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .rep_fail   (rep_fail)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Hold reset low across one rising edge, release on the next falling edge.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one byte and return just after the edge that accepts it.
    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Let the four pair steps of the latest byte complete, then sit on a falling edge.
    task automatic waitSteps();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Pop one FIFO entry (called on a falling edge, returns on a falling edge).
    task automatic popOne();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (fifo_level !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_level: got %0d required 0", fifo_level);
        end
        testsRun++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_out: valid=%0b data=%h required 0/00", out_valid, out_data);
        end
        testsRun++;
        if (rep_fail !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_rep: got %0b required 0", rep_fail);
        end
        rst_n = 1'b1;
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    // 66,66 -> pairs 01 10 01 10 twice -> 0101_0101.
    task automatic test_pairs();
        doReset();
        out_ready = 1'b0;
        sendByte(8'h66);
        waitSteps();
        testsRun++;
        if (fifo_level !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL pairs_partial: level=%0d required 0", fifo_level);
        end
        sendByte(8'h66);
        waitSteps();
        testsRun++;
        if (out_data !== 8'h55 || out_valid !== 1'b1 || fifo_level !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL pairs_byte: data=%h valid=%0b level=%0d required 55/1/1",
                     out_data, out_valid, fifo_level);
        end
        popOne();
        testsRun++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL pairs_pop: level=%0d valid=%0b required 0/0", fifo_level, out_valid);
        end
    endtask

    // 00 and FF emit nothing; 99,99 -> 1010_1010.
    task automatic test_discard();
        doReset();
        out_ready = 1'b0;
        sendByte(8'h00);
        sendByte(8'hFF);
        waitSteps();
        testsRun++;
        if (fifo_level !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL discard_none: level=%0d required 0", fifo_level);
        end
        sendByte(8'h99);
        sendByte(8'h99);
        waitSteps();
        testsRun++;
        if (out_data !== 8'hAA || fifo_level !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL discard_byte: data=%h level=%0d required AA/1", out_data, fifo_level);
        end
    endtask

    task automatic test_repetition();
        doReset();
        out_ready = 1'b1;
        repeat (3) sendByte(8'hA5);
        testsRun++;
        if (rep_fail !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rep_three: got %0b required 0", rep_fail);
        end
        sendByte(8'hA5);
        testsRun++;
        if (rep_fail !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rep_fourth: got %0b required 1", rep_fail);
        end
        sendByte(8'h3C);
        waitSteps();
        testsRun++;
        if (rep_fail !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rep_sticky: got %0b required 1", rep_fail);
        end
        doReset();
        for (int i = 0; i < 4; i++) begin
            sendByte(8'hA5);
            sendByte(8'h3C);
        end
        waitSteps();
        testsRun++;
        if (rep_fail !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rep_alternate: got %0b required 0", rep_fail);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        doReset();
        out_ready = 1'b0;
        repeat (8) sendByte(8'h66);
        waitSteps();
        testsRun++;
        if (fifo_level !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL bp_full: level=%0d required 4", fifo_level);
        end
        sendByte(8'h66);
        sendByte(8'h66);
        repeat (6) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL bp_stall: in_ready=%0b level=%0d required 0/4", in_ready, fifo_level);
        end
        popOne();
        testsRun++;
        if (in_ready !== 1'b1 || fifo_level !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL bp_release: in_ready=%0b level=%0d required 1/4", in_ready, fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (out_data !== 8'h55 || out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL bp_drain%0d: data=%h valid=%0b required 55/1", i, out_data, out_valid);
            end
            popOne();
        end
        testsRun++;
        if (fifo_level !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL bp_empty: level=%0d required 0", fifo_level);
        end
    endtask

    task automatic test_reset_midpair();
        doReset();
        out_ready = 1'b0;
        repeat (4) sendByte(8'h66);
        waitSteps();
        sendByte(8'h66);
        sendByte(8'h66);
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (fifo_level !== 3'd2 || rep_fail !== 1'b1 || in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_setup: level=%0d rep=%0b in_ready=%0b required 2/1/0",
                     fifo_level, rep_fail, in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        testsRun++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0 || rep_fail !== 1'b0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: level=%0d valid=%0b rep=%0b in_ready=%0b required 0/0/0/1",
                     fifo_level, out_valid, rep_fail, in_ready);
        end
        sendByte(8'h66);
        sendByte(8'h66);
        waitSteps();
        testsRun++;
        if (out_data !== 8'h55 || fifo_level !== 3'd1 || rep_fail !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_after: data=%h level=%0d rep=%0b required 55/1/0",
                     out_data, fifo_level, rep_fail);
        end
    endtask

    task automatic test_enable();
        doReset();
        out_ready = 1'b0;
        repeat (4) sendByte(8'h66);
        waitSteps();
        sendByte(8'h99);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ena       = 1'b0;
        out_ready = 1'b1;
        testsRun++;
        if (out_data !== 8'h55 || fifo_level !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL ena_head: data=%h level=%0d required 55/2", out_data, fifo_level);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        ena       = 1'b1;
        out_ready = 1'b0;
        testsRun++;
        if (fifo_level !== 3'd0 || in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ena_frozen: level=%0d in_ready=%0b required 0/0", fifo_level, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ena_resume3: in_ready=%0b required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ena_resume4: in_ready=%0b required 1", in_ready);
        end
        sendByte(8'h99);
        waitSteps();
        testsRun++;
        if (out_data !== 8'hAA || fifo_level !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL ena_byte: data=%h level=%0d required AA/1", out_data, fifo_level);
        end
    endtask

    // Run every scenario in sequence and report.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_pairs();
        test_discard();
        test_repetition();
        test_back_to_back();
        test_reset_midpair();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
